// File: rtl/axi_burst_master.sv
// AXI4 burst master: writes one LEN-beat burst of 1..LEN to C_M_TARGET_BASE, then checks B.
// Define AXI_BURST_MASTER_READBACK_EN to also read the burst back and compare the data.
module axi_burst_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_BURST_LEN      = 16,
  parameter logic [63:0] C_M_TARGET_BASE    = 64'h0
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              i_start,
  output logic                              o_done,
  output logic                              o_error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                        M_AXI_ARLEN,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RLAST,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned AW     = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW     = C_M_AXI_DATA_WIDTH;
  localparam int unsigned BEAT_W = 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_M_BURST_LEN - 1);
  localparam logic [7:0]        AXLEN     = 8'(C_M_BURST_LEN - 1);
  localparam logic [AW-1:0]     BASE_ADDR = AW'(C_M_TARGET_BASE);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN} state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               error_q, error_d;
  logic               done_q, done_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               wlast_q, wlast_d;
  logic               bready_q, bready_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic [DW-1:0]      wdata_q, wdata_d;

  logic aw_hs_c, w_hs_c, b_hs_c;
  assign aw_hs_c = awvalid_q & M_AXI_AWREADY;
  assign w_hs_c  = wvalid_q & M_AXI_WREADY;
  assign b_hs_c  = bready_q & M_AXI_BVALID;

`ifdef AXI_BURST_MASTER_READBACK_EN
  logic ar_hs_c, r_hs_c, r_bad_c;
  assign ar_hs_c = arvalid_q & M_AXI_ARREADY;
  assign r_hs_c  = rready_q & M_AXI_RVALID;
  // Beat n must carry n+1, OKAY response, and RLAST exactly on the final beat
  assign r_bad_c = (M_AXI_RDATA != (DW'(beat_q) + DW'(1))) ||
                   (M_AXI_RRESP != 2'b00) ||
                   (M_AXI_RLAST != (beat_q == LAST_BEAT));
`else
  logic unused_rd;
  assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID};
`endif

  // Next-state, beat counter and sticky error
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = WADDR;
          error_d = 1'b0;
        end
      end
      WADDR: if (aw_hs_c) state_d = WDATA;
      WDATA: begin
        if (w_hs_c) begin
          if (beat_q == LAST_BEAT) begin
            state_d = WRESP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      WRESP: begin
        if (b_hs_c) begin
          if (M_AXI_BRESP != 2'b00) error_d = 1'b1;
`ifdef AXI_BURST_MASTER_READBACK_EN
          state_d = RADDR;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef AXI_BURST_MASTER_READBACK_EN
      RADDR: if (ar_hs_c) state_d = RDATA;
      RDATA: begin
        if (r_hs_c) begin
          if (r_bad_c) error_d = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = FIN;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change with the state
  always_comb begin
    awvalid_d = (state_d == WADDR);
    wvalid_d  = (state_d == WDATA);
    wlast_d   = (state_d == WDATA) && (beat_d == LAST_BEAT);
    bready_d  = (state_d == WRESP);
    done_d    = (state_d == FIN);
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
`ifdef AXI_BURST_MASTER_READBACK_EN
    arvalid_d = (state_d == RADDR);
    rready_d  = (state_d == RDATA);
`endif
    addr_d    = BASE_ADDR;
    len_d     = AXLEN;
    wdata_d   = (state_d == WDATA) ? (DW'(beat_d) + DW'(1)) : wdata_q;
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      error_q   <= error_d;
      done_q    <= done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_done        = done_q;
  assign o_error       = error_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: transaction-level model checked every cycle,
// directed scenarios for back-pressure, bad responses, mid-burst reset and LEN=1.
`timescale 1ns/1ps
module tb_axi_burst_master;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LEN = 16;
  localparam logic [63:0] BASE = 64'h0000_1000;
`ifdef AXI_BURST_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          i_start, o_done, o_error;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic          awvalid, awready, wvalid, wready, wlast;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready, rlast;

  logic          start1, done1, error1;
  logic [AW-1:0] awaddr1, araddr1;
  logic [7:0]    awlen1, arlen1;
  logic          awvalid1, wvalid1, wlast1, bready1, arvalid1, rready1;
  logic [DW-1:0] wdata1;
  logic [3:0]    wstrb1;
  logic          one = 1'b1;
  logic [1:0]    zero2 = 2'b00;
  logic [DW-1:0] rdata1 = 32'd1;

  axi_burst_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
                     .C_M_BURST_LEN(LEN), .C_M_TARGET_BASE(BASE)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .i_start(i_start), .o_done(o_done), .o_error(o_error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready));

  axi_burst_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
                     .C_M_BURST_LEN(1), .C_M_TARGET_BASE(64'h0)) dut1 (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .i_start(start1), .o_done(done1), .o_error(error1),
    .M_AXI_AWADDR(awaddr1), .M_AXI_AWLEN(awlen1), .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(one),
    .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WLAST(wlast1), .M_AXI_WVALID(wvalid1),
    .M_AXI_WREADY(one), .M_AXI_BRESP(zero2), .M_AXI_BVALID(one), .M_AXI_BREADY(bready1),
    .M_AXI_ARADDR(araddr1), .M_AXI_ARLEN(arlen1), .M_AXI_ARVALID(arvalid1), .M_AXI_ARREADY(one),
    .M_AXI_RDATA(rdata1), .M_AXI_RRESP(zero2), .M_AXI_RLAST(one), .M_AXI_RVALID(one),
    .M_AXI_RREADY(rready1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: expected outputs follow from handshake counts alone
  bit m_started, m_aw_done, m_b_done, m_ar_done, m_err, m_done_next;
  int m_wb, m_rb;

  always @(negedge clk) begin : cmp
    bit e_aw, e_w, e_b, e_ar, e_r, hs_aw, hs_w, hs_b, hs_ar, hs_r, busy, fin_now;
    if (!rst_n) begin
      chk("rst_ctrl", {awvalid, wvalid, wlast, bready, arvalid, rready, o_done, o_error}, 8'h00);
      chk("rst_addr", {awaddr, awlen}, 40'h0);
      chk("rst_wdata", wdata, 32'h0);
      m_started = 0; m_aw_done = 0; m_b_done = 0; m_ar_done = 0;
      m_err = 0; m_done_next = 0; m_wb = 0; m_rb = 0;
    end else begin
      e_aw = m_started && !m_aw_done;
      e_w  = m_aw_done && (m_wb < LEN);
      e_b  = m_started && (m_wb == LEN) && !m_b_done;
      e_ar = RB && m_b_done && !m_ar_done;
      e_r  = RB && m_ar_done && (m_rb < LEN);
      chk("valids", {awvalid, wvalid, bready, arvalid, rready}, {e_aw, e_w, e_b, e_ar, e_r});
      chk("exclusive_valid", 64'(int'(awvalid) + int'(wvalid) + int'(arvalid) <= 1), 1);
      chk("o_done", o_done, m_done_next);
      chk("o_error", o_error, m_err);
      chk("wstrb", wstrb, 4'hF);
      if (awvalid) chk("aw_payload", {awaddr, awlen}, {BASE[31:0], 8'(LEN - 1)});
      if (arvalid) chk("ar_payload", {araddr, arlen}, {BASE[31:0], 8'(LEN - 1)});
      if (wvalid)  chk("w_payload", {wdata, wlast}, {32'(m_wb + 1), 1'(m_wb == LEN - 1)});
      hs_aw = e_aw && awready;
      hs_w  = e_w && wready;
      hs_b  = e_b && bvalid;
      hs_ar = e_ar && arready;
      hs_r  = e_r && rvalid;
      busy    = m_started;
      fin_now = m_done_next;
      m_done_next = RB ? (hs_r && (m_rb == LEN - 1)) : hs_b;
      if (hs_b && bresp != 2'b00) m_err = 1;
      if (hs_r && (rdata != 32'(m_rb + 1) || rresp != 2'b00 || rlast != (m_rb == LEN - 1))) m_err = 1;
      if (hs_aw) m_aw_done = 1;
      if (hs_w)  m_wb++;
      if (hs_b)  m_b_done = 1;
      if (hs_ar) m_ar_done = 1;
      if (hs_r)  m_rb++;
      if (fin_now) begin
        m_started = 0; m_aw_done = 0; m_b_done = 0; m_ar_done = 0; m_wb = 0; m_rb = 0;
      end
      if (i_start && !busy) begin
        m_started = 1; m_err = 0;
      end
    end
  end

  // Slave responder state
  bit       bp;
  logic [1:0] cfg_bresp;
  int       cfg_bad_beat;
  int       rs_wbeats, rs_rbeat, wsum, wlast_idx;
  bit       rs_rpend;

  task automatic rs_clear();
    rs_wbeats = 0; rs_rbeat = 0; rs_rpend = 0; wsum = 0; wlast_idx = -1;
    bvalid = 0; bresp = 0; rvalid = 0; rlast = 0; rdata = 0; rresp = 0;
  endtask

  task automatic cyc();
    bit hw, hb, ha, hr;
    @(negedge clk);
    hw = wvalid && wready;
    hb = bvalid && bready;
    ha = arvalid && arready;
    hr = rvalid && rready;
    if (hw) begin
      wsum += int'(wdata);
      if (wlast) wlast_idx = rs_wbeats;
    end
    @(posedge clk);
    #2;
    i_start = 0;
    if (hw) rs_wbeats++;
    if (hw && rs_wbeats == LEN) begin bvalid = 1; bresp = cfg_bresp; end
    if (hb) begin bvalid = 0; bresp = 0; end
    if (ha) rs_rpend = 1;
    if (hr) rs_rbeat++;
    if (rs_rpend && rs_rbeat < LEN) begin
      rvalid = 1;
      rdata  = (rs_rbeat == cfg_bad_beat) ? 32'hDEAD : 32'(rs_rbeat + 1);
      rlast  = (rs_rbeat == LEN - 1);
    end else begin
      rvalid = 0; rlast = 0; rdata = 0;
    end
    awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_txn(input bit mid_start, output int lat);
    rs_clear();
    i_start = 1;
    cyc();
    lat = 1;
    chk("start_to_awvalid", awvalid, 1);
    chk("start_clears_err", o_error, 0);
    while (!o_done && lat < 2000) begin
      cyc();
      lat++;
      if (mid_start && lat == 5) i_start = 1;
    end
    chk("txn_timeout", o_done, 1);
    cyc();
    chk("done_pulse_width", o_done, 0);
  endtask

  task automatic run_len1();
    int n1 = 0;
    int wb1 = 0;
    start1 = 1;
    @(posedge clk);
    #2;
    start1 = 0;
    chk("len1_awvalid", awvalid1, 1);
    chk("len1_awlen", awlen1, 8'h00);
    while (!done1 && n1 < 100) begin
      @(negedge clk);
      if (wvalid1) begin
        chk("len1_wlast", wlast1, 1);
        chk("len1_wdata", wdata1, 32'd1);
        wb1++;
      end
      @(posedge clk);
      #2;
      n1++;
    end
    chk("len1_done", done1, 1);
    chk("len1_wbeats", wb1, 1);
    chk("len1_err", error1, 0);
  endtask

  initial begin
    int lat;
    rst_n = 0; i_start = 0; start1 = 0;
    awready = 1; wready = 1; arready = 1;
    bp = 0; cfg_bresp = 2'b00; cfg_bad_beat = -1;
    rs_clear();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wstrb", wstrb, 4'hF);
    chk("rst_valid_lit", {awvalid, wvalid, arvalid, o_done, o_error}, 5'b0);
    rst_n = 1;
    cyc(); cyc();

    // Always-ready LEN=16 burst
    run_txn(1'b0, lat);
    chk("t1_latency", lat, RB ? 36 : 19);
    chk("t1_wsum", wsum, 136);
    chk("t1_wlast_idx", wlast_idx, 15);
    chk("t1_wbeats", rs_wbeats, 16);
    chk("t1_err", o_error, 0);

    // Random back-pressure on AW/W/AR, plus a start pulse while busy
    bp = 1;
    run_txn(1'b1, lat);
    chk("t2_wsum", wsum, 136);
    chk("t2_wlast_idx", wlast_idx, 15);
    chk("t2_err", o_error, 0);
    bp = 0;
    cyc();

    // SLVERR on B
    cfg_bresp = 2'b10;
    run_txn(1'b0, lat);
    chk("t3_err", o_error, 1);
    cfg_bresp = 2'b00;
    cyc(); cyc();
    chk("t3_err_sticky", o_error, 1);

`ifdef AXI_BURST_MASTER_READBACK_EN
    // Corrupt read data at beat 5
    cfg_bad_beat = 5;
    run_txn(1'b0, lat);
    chk("t4_bad_rdata_err", o_error, 1);
    cfg_bad_beat = -1;
    cyc();
`endif

    // Clean run clears the sticky error
    run_txn(1'b0, lat);
    chk("t5_err_cleared", o_error, 0);
    cyc();

    // Reset asserted at beat 7 of the write burst
    rs_clear();
    i_start = 1;
    cyc();
    for (int i = 0; i < 100 && rs_wbeats < 7; i++) cyc();
    chk("t6_at_beat7", rs_wbeats, 7);
    rst_n = 0;
    #1;
    chk("t6_async_valids", {awvalid, wvalid, arvalid, bready, rready, wlast}, 6'b0);
    cyc(); cyc();
    rst_n = 1;
    rs_clear();
    cyc(); cyc(); cyc();
    chk("t6_idle_after_rst", {awvalid, wvalid, bready, arvalid, o_done}, 5'b0);
    run_txn(1'b0, lat);
    chk("t6_latency_after_rst", lat, RB ? 36 : 19);
    chk("t6_wsum", wsum, 136);

    run_len1();
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
